kernel_addr_sequencer: RTL and testbench
========================================

# kernel_addr_sequencer

Parametrised successor to the pointer array: generates per-unit operand addresses for one kernel pass across `N_UNITS` compute units, with a valid/ready handshake instead of a bare step strobe. It has configurable element and unit strides, and compacts active units so that unit base addresses are contiguous. It reports busy/done, so the TTPU controller can launch a pass and wait for completion.

## Interface
- `N_UNITS`, 4: number of compute units / address lanes.
- `ADDR_W`, 32: address width.
- `CNT_W`, 16: width of kernel element counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch pulse; sampled only in IDLE.
- `start_addr`  in  ADDR_W  base address of rank-0 unit's kernel.
- `unit_stride`  in  ADDR_W  address distance between consecutive active units.
- `elem_stride`  in  8  address increment per element step.
- `kernel_size`  in  CNT_W  elements per unit per pass.
- `bias_base`  in  ADDR_W  base of bias vector.
- `active_units`  in  N_UNITS  unit enable mask.
- `addr_valid`  out  1  address set valid.
- `addr_ready`  in  1  consumer accepts current address set.
- `addr_out`  out  N_UNITS x ADDR_W  per-unit element address.
- `bias_addr`  out  N_UNITS x ADDR_W  per-unit bias address.
- `unit_valid`  out  N_UNITS  latched active mask for the pass.
- `elem_idx`  out  CNT_W  index of current element.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at end of pass.

## Operation
- On `start` in IDLE, latch all config inputs. Config changes during a pass are ignored.
- rank(i) = number of set bits in latched `active_units[i-1:0]`.
- For active unit i:
  - `addr_out[i] = start_addr + rank(i)*unit_stride + elem_idx*elem_stride`
  - `bias_addr[i] = bias_base + rank(i)*BIAS_WORD_BYTES`
- For inactive units: `addr_out`, `bias_addr`, and `unit_valid` are 0.
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- FSM states:
  - IDLE: go to RUN on `start` when `kernel_size` != 0 and `active_units` != 0. Otherwise go straight to DONE; no address is ever presented.
  - RUN: `addr_valid`=1. A handshake is `addr_valid & addr_ready`.
    - Handshake with `elem_idx` < `kernel_size`-1: increment `elem_idx`.
    - Handshake with `elem_idx` == `kernel_size`-1: go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE. `addr_valid`=0.
- `start` in RUN or DONE is ignored.
- While `addr_ready`=0, all address outputs hold stable.
- Reset in any state: immediately back to IDLE with all outputs at reset values; any pass in progress is abandoned.

## Timing
- Reset values: state IDLE; `addr_valid`, `busy`, `done`, `elem_idx`, `unit_valid`, and all `addr_out`/`bias_addr` are 0.
- All outputs are registered.
- `start` sampled at edge T:
  - RUN path: `busy`, `addr_valid`, and element-0 addresses are visible after T.
  - Zero-work path: `done` is visible after T.
- Handshake at edge E: next address set is visible after E, so back-to-back handshakes give one element per cycle.
- Final handshake at edge E: `done`=1 for the cycle after E, and `addr_valid` drops at E.
- Pass length with `addr_ready` held at 1: `kernel_size` cycles of RUN plus 1 cycle of DONE.
- Earliest restart: `start` sampled in the cycle after DONE, i.e. in IDLE.

## Structure
- Shared package `ttpu_addr_pkg` holds:
  - state enum `seq_state_t` (IDLE, RUN, DONE);
  - constant `BIAS_WORD_BYTES` = 4;
  - default `ADDR_W`/`CNT_W` localparams.
- Sub-module `active_rank`: combinational exclusive prefix popcount over `N_UNITS` bits, outputting `rank[i]`. It is instantiated on the latched mask.
- Per-unit base addresses are computed once at `start` and registered, so the running path only adds `elem_idx*elem_stride`. Implement this as a running offset register that adds `elem_stride` on each handshake; no multiplier.

## Test plan
- Basic pass:
  - Stimulus: N=4, `start_addr`=0x1000, `unit_stride`=0x100, `elem_stride`=4, `kernel_size`=3, `active_units`=1011, `bias_base`=0x2000, `addr_ready`=1.
  - Expected `addr_out`: 0x1000/0x1100/0/0x1200, then +4, then +8.
  - Expected `bias_addr`: 0x2000/0x2004/0/0x2008.
  - Expected end: `done` after 3 handshakes.
- Backpressure: same config with `addr_ready`=0 for 5 cycles at `elem_idx`=1 → addresses hold at 0x1004/0x1104/0/0x1204, and `elem_idx` stays 1.
- Zero work: `kernel_size`=0 (and separately `active_units`=0) → `done` in the cycle after start, `addr_valid` never 1.
- Wrap-around: `start_addr`=0xFFFF_FFF8, `elem_stride`=4, `kernel_size`=4, mask 0001 → unit0 sees 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Reset and restart:
  - `rst` asserted at `elem_idx`=1 → next cycle all outputs 0 and state IDLE.
  - A fresh `start` then begins at element 0.
  - `start` pulsed during RUN is ignored, and the pass count is unchanged.

Source files
------------

// File: rtl/ttpu_addr_pkg.sv
// Shared types and constants for the TTPU kernel address sequencer.
package ttpu_addr_pkg;

  // Pass control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Byte distance between consecutive bias words in the bias vector
  localparam int BIAS_WORD_BYTES = 4;

  // Default datapath widths
  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/active_rank.sv
// Exclusive prefix popcount: rank[i] = number of set bits in mask[i-1:0].
// Each lane counts its own masked bits, so lanes share no combinational chain.
module active_rank #(
  parameter int N_UNITS = 4,
  parameter int RANK_W  = $clog2(N_UNITS + 1)
) (
  input  logic [N_UNITS-1:0]             mask,
  output logic [N_UNITS-1:0][RANK_W-1:0] rank
);

  genvar gi;
  generate
    for (gi = 0; gi < N_UNITS; gi++) begin : g_rank
      // Select only the lanes strictly below this one
      localparam logic [N_UNITS:0] LOW_FULL = (N_UNITS + 1)'((1 << gi) - 1);
      logic [N_UNITS-1:0] w_low;
      assign w_low      = mask & LOW_FULL[N_UNITS-1:0];
      assign rank[gi]   = RANK_W'($countones(w_low));
    end
  endgenerate

endmodule

// File: rtl/kernel_addr_sequencer.sv
// Generates per-unit operand and bias addresses for one kernel pass, one
// element per accepted handshake, with active units compacted by rank.
module kernel_addr_sequencer
  import ttpu_addr_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               start_addr,
  input  logic [ADDR_W-1:0]               unit_stride,
  input  logic [7:0]                      elem_stride,
  input  logic [CNT_W-1:0]                kernel_size,
  input  logic [ADDR_W-1:0]               bias_base,
  input  logic [N_UNITS-1:0]              active_units,
  output logic                            addr_valid,
  input  logic                            addr_ready,
  output logic [N_UNITS-1:0][ADDR_W-1:0]  addr_out,
  output logic [N_UNITS-1:0][ADDR_W-1:0]  bias_addr,
  output logic [N_UNITS-1:0]              unit_valid,
  output logic [CNT_W-1:0]                elem_idx,
  output logic                            busy,
  output logic                            done
);

  localparam int RANK_W = $clog2(N_UNITS + 1);

  seq_state_t r_state, w_state_next;

  logic                           r_valid, r_busy, r_done;
  logic                           w_valid_next, w_busy_next, w_done_next;
  logic [CNT_W-1:0]               r_elem_idx;
  logic [CNT_W-1:0]               r_kernel_size;
  logic [ADDR_W-1:0]              r_elem_stride;
  logic [N_UNITS-1:0]             r_unit_valid;
  logic [N_UNITS-1:0][ADDR_W-1:0] r_addr;
  logic [N_UNITS-1:0][ADDR_W-1:0] r_bias;

  logic                           w_launch, w_has_work, w_hs, w_last, w_step;
  logic [N_UNITS-1:0][RANK_W-1:0] w_rank;
  logic [N_UNITS-1:0][ADDR_W-1:0] w_unit_off;

  assign w_launch   = start && (r_state == IDLE);
  assign w_has_work = (kernel_size != '0) && (active_units != '0);
  assign w_hs       = (r_state == RUN) && addr_ready;
  assign w_last     = (r_elem_idx == r_kernel_size - CNT_W'(1));
  assign w_step     = w_hs && !w_last;

  // Ranks are only consumed at launch, so they are taken from the mask
  // being latched in that same cycle.
  active_rank #(
    .N_UNITS (N_UNITS),
    .RANK_W  (RANK_W)
  ) u_active_rank (
    .mask (active_units),
    .rank (w_rank)
  );

  // Rank-scaled unit offset as a running sum over active lanes (no multiply)
  always_comb begin
    logic [ADDR_W-1:0] acc;
    acc        = '0;
    w_unit_off = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      w_unit_off[i] = acc;
      if (active_units[i]) acc = acc + unit_stride;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start) w_state_next = w_has_work ? RUN : DONE;
      RUN:  if (w_hs && w_last) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the next state, registered below
  always_comb begin
    w_valid_next = (w_state_next == RUN);
    w_busy_next  = (w_state_next != IDLE);
    w_done_next  = (w_state_next == DONE);
  end

  // Datapath: latch config at launch, advance lane addresses per handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_elem_idx    <= '0;
      r_kernel_size <= '0;
      r_elem_stride <= '0;
      r_unit_valid  <= '0;
      r_addr        <= '0;
      r_bias        <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      if (w_launch) begin
        r_elem_idx    <= '0;
        r_kernel_size <= kernel_size;
        r_elem_stride <= ADDR_W'(elem_stride);
        for (int i = 0; i < N_UNITS; i++) begin
          if (w_has_work && active_units[i]) begin
            r_unit_valid[i] <= 1'b1;
            r_addr[i]       <= start_addr + w_unit_off[i];
            r_bias[i]       <= bias_base
                               + ADDR_W'(w_rank[i]) * ADDR_W'(BIAS_WORD_BYTES);
          end else begin
            r_unit_valid[i] <= 1'b0;
            r_addr[i]       <= '0;
            r_bias[i]       <= '0;
          end
        end
      end else if (w_step) begin
        r_elem_idx <= r_elem_idx + CNT_W'(1);
        for (int i = 0; i < N_UNITS; i++) begin
          if (r_unit_valid[i]) r_addr[i] <= r_addr[i] + r_elem_stride;
        end
      end
    end
  end

  assign addr_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign elem_idx   = r_elem_idx;
  assign unit_valid = r_unit_valid;
  assign addr_out   = r_addr;
  assign bias_addr  = r_bias;

endmodule

// File: tb/tb_kernel_addr_sequencer.sv
// Directed self-checking bench for kernel_addr_sequencer.
module tb_kernel_addr_sequencer;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       start_addr;
  logic [31:0]       unit_stride;
  logic [7:0]        elem_stride;
  logic [15:0]       kernel_size;
  logic [31:0]       bias_base;
  logic [3:0]        active_units;
  logic              addr_valid;
  logic              addr_ready;
  logic [3:0][31:0]  addr_out;
  logic [3:0][31:0]  bias_addr;
  logic [3:0]        unit_valid;
  logic [15:0]       elem_idx;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int pass_cnt = 0;
  int pass_before;

  always #5 clk = ~clk;

  kernel_addr_sequencer #(.N_UNITS(4), .ADDR_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .unit_stride  (unit_stride),
    .elem_stride  (elem_stride),
    .kernel_size  (kernel_size),
    .bias_base    (bias_base),
    .active_units (active_units),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr_out     (addr_out),
    .bias_addr    (bias_addr),
    .unit_valid   (unit_valid),
    .elem_idx     (elem_idx),
    .busy         (busy),
    .done         (done)
  );

  // Count completed passes mid-cycle
  always @(negedge clk) if (done === 1'b1) pass_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_lanes(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
    chk({tag, ".a0"}, addr_out[0], a0);
    chk({tag, ".a1"}, addr_out[1], a1);
    chk({tag, ".a2"}, addr_out[2], a2);
    chk({tag, ".a3"}, addr_out[3], a3);
  endtask

  task automatic basic_cfg();
    start_addr   = 32'h0000_1000;
    unit_stride  = 32'h0000_0100;
    elem_stride  = 8'd4;
    kernel_size  = 16'd3;
    active_units = 4'b1011;
    bias_base    = 32'h0000_2000;
  endtask

  task automatic launch();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr_ready = 1'b1;
    basic_cfg();
    cyc(); cyc();
    chk("rst.valid", {31'd0, addr_valid}, 32'd0);
    chk("rst.busy",  {31'd0, busy}, 32'd0);
    chk("rst.done",  {31'd0, done}, 32'd0);
    chk("rst.idx",   {16'd0, elem_idx}, 32'd0);
    chk("rst.uv",    {28'd0, unit_valid}, 32'd0);
    chk_lanes("rst", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("rst.b0",    bias_addr[0], 32'd0);
    rst = 1'b0;
    cyc();

    // Basic pass
    launch();
    chk("bas.valid", {31'd0, addr_valid}, 32'd1);
    chk("bas.busy",  {31'd0, busy}, 32'd1);
    chk("bas.idx0",  {16'd0, elem_idx}, 32'd0);
    chk("bas.uv",    {28'd0, unit_valid}, 32'hB);
    chk_lanes("bas.e0", 32'h1000, 32'h1100, 32'h0, 32'h1200);
    chk("bas.b0", bias_addr[0], 32'h2000);
    chk("bas.b1", bias_addr[1], 32'h2004);
    chk("bas.b2", bias_addr[2], 32'h0);
    chk("bas.b3", bias_addr[3], 32'h2008);
    cyc();
    chk("bas.idx1",  {16'd0, elem_idx}, 32'd1);
    chk_lanes("bas.e1", 32'h1004, 32'h1104, 32'h0, 32'h1204);
    cyc();
    chk_lanes("bas.e2", 32'h1008, 32'h1108, 32'h0, 32'h1208);
    cyc();
    chk("bas.done",  {31'd0, done}, 32'd1);
    chk("bas.dvld",  {31'd0, addr_valid}, 32'd0);
    chk("bas.dbusy", {31'd0, busy}, 32'd1);
    cyc();
    chk("bas.done0", {31'd0, done}, 32'd0);
    chk("bas.idle",  {31'd0, busy}, 32'd0);

    // Backpressure at element 1
    launch();
    cyc();
    addr_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("bp.idx",   {16'd0, elem_idx}, 32'd1);
    chk("bp.valid", {31'd0, addr_valid}, 32'd1);
    chk_lanes("bp.hold", 32'h1004, 32'h1104, 32'h0, 32'h1204);
    addr_ready = 1'b1;
    cyc();
    chk_lanes("bp.e2", 32'h1008, 32'h1108, 32'h0, 32'h1208);
    cyc();
    chk("bp.done", {31'd0, done}, 32'd1);
    cyc();

    // Zero work: kernel_size = 0
    kernel_size = 16'd0;
    launch();
    chk("zk.done",  {31'd0, done}, 32'd1);
    chk("zk.valid", {31'd0, addr_valid}, 32'd0);
    cyc();
    chk("zk.done0", {31'd0, done}, 32'd0);
    chk("zk.valid1", {31'd0, addr_valid}, 32'd0);

    // Zero work: no active units
    kernel_size = 16'd3; active_units = 4'b0000;
    launch();
    chk("zm.done",  {31'd0, done}, 32'd1);
    chk("zm.valid", {31'd0, addr_valid}, 32'd0);
    cyc();
    chk("zm.valid1", {31'd0, addr_valid}, 32'd0);

    // Wrap-around on unit 0
    start_addr = 32'hFFFF_FFF8; elem_stride = 8'd4; kernel_size = 16'd4;
    active_units = 4'b0001;
    launch();
    chk_lanes("wr.e0", 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);
    cyc();
    chk("wr.e1", addr_out[0], 32'hFFFF_FFFC);
    cyc();
    chk("wr.e2", addr_out[0], 32'h0000_0000);
    cyc();
    chk("wr.e3", addr_out[0], 32'h0000_0004);
    cyc();
    chk("wr.done", {31'd0, done}, 32'd1);
    cyc();

    // Reset mid-pass
    basic_cfg();
    launch();
    cyc();
    chk("rr.idx1", {16'd0, elem_idx}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rr.valid", {31'd0, addr_valid}, 32'd0);
    chk("rr.busy",  {31'd0, busy}, 32'd0);
    chk("rr.idx",   {16'd0, elem_idx}, 32'd0);
    chk("rr.uv",    {28'd0, unit_valid}, 32'd0);
    chk("rr.a0",    addr_out[0], 32'd0);
    chk("rr.b3",    bias_addr[3], 32'd0);
    cyc();
    chk("rr.idle",  {31'd0, busy}, 32'd0);

    // Fresh start, with a stray start and new config during RUN
    pass_before = pass_cnt;
    launch();
    chk("rs.idx0", {16'd0, elem_idx}, 32'd0);
    chk_lanes("rs.e0", 32'h1000, 32'h1100, 32'h0, 32'h1200);
    start_addr = 32'h0000_5000; active_units = 4'b1111;
    launch();
    chk_lanes("rs.e1", 32'h1004, 32'h1104, 32'h0, 32'h1204);
    cyc();
    chk("rs.idx2", {16'd0, elem_idx}, 32'd2);
    cyc();
    chk("rs.done", {31'd0, done}, 32'd1);
    cyc();
    chk("rs.passes", pass_cnt - pass_before, 32'd1);
    chk("rs.idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
